// File: rtl/riscv_lsu_if.sv
// Data-memory port between the LSU (master) and the data memory (slave).
// Single outstanding request: req/addr/we/wdata/wmask hold until ack.
interface riscv_lsu_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_wmask_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
      output mem_ack_i, mem_rdata_i
   );
endinterface

// File: rtl/riscv_lsu.sv
// RV32I MEM stage: loads/stores over a req/ack memory port, pass-through of
// non-memory results, lane alignment, sign/zero extension, misalignment,
// illegal-width and bus-timeout reporting. One instruction in flight.
module riscv_lsu #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ex_valid_i,
   output logic               ex_ready_o,
   input  logic [31:0]        ex_alu_p_i,
   input  logic [31:0]        ex_wdata_i,
   input  logic [2:0]         ex_funct3_i,
   input  logic               ex_load_i,
   input  logic               ex_store_i,
   input  logic [4:0]         ex_rd_i,
   input  logic               ex_rd_we_i,
   riscv_lsu_if.master        mem,
   output logic               wb_valid_o,
   input  logic               wb_ready_i,
   output logic [31:0]        wb_result_o,
   output logic [4:0]         wb_rd_o,
   output logic               wb_rd_we_o,
   output logic [1:0]         wb_exc_code_o
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2} state_t;

   localparam logic [1:0] EXC_NONE  = 2'b00;
   localparam logic [1:0] EXC_MISAL = 2'b01;
   localparam logic [1:0] EXC_TOUT  = 2'b10;
   localparam logic [1:0] EXC_ILL   = 2'b11;

   // Stores allow only B/H/W; loads additionally allow BU/HU.
   function automatic logic funct3_legal(input logic [2:0] f3, input logic st);
      logic ok;
      ok = 1'b0;
      if (st) begin
         case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            default:                ok = 1'b0;
         endcase
      end else begin
         case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            default:                                ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return off[0];
         2'b10:   return (off != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
      case (f3[1:0])
         2'b00:   return {4{w[7:0]}};
         2'b01:   return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   // Shift the addressed lane down to bit 0, then extend by width/sign.
   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
      logic [31:0] sh;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'h000000, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'h0000, sh[15:0]};
         default: return rdata;
      endcase
   endfunction

   state_t         state_r, next_state_s;
   logic           accept_s, is_mem_s, go_req_s, timeout_s;
   logic [1:0]     exc_s;
   logic [CNT_W-1:0] cnt_r;
   logic           mem_req_r, mem_we_r;
   logic [31:0]    mem_addr_r, mem_wdata_r;
   logic [3:0]     mem_wmask_r;
   logic [2:0]     op_f3_r;
   logic [31:0]    op_addr_r;
   logic [4:0]     op_rd_r;
   logic           op_rd_we_r, op_st_r;
   logic           wb_valid_r, wb_rd_we_r;
   logic [31:0]    wb_result_r;
   logic [4:0]     wb_rd_r;
   logic [1:0]     wb_exc_r;

   assign ex_ready_o = (state_r == ST_IDLE) | ((state_r == ST_RESP) & wb_ready_i);
   assign accept_s   = ex_valid_i & ex_ready_o;
   assign is_mem_s   = ex_load_i | ex_store_i;
   assign go_req_s   = is_mem_s & (exc_s == EXC_NONE);
   assign timeout_s  = (TIMEOUT != 0) && (cnt_r == CNT_W'(TIMEOUT));

   // Classify the incoming instruction; width legality outranks alignment.
   always_comb begin
      exc_s = EXC_NONE;
      if (!is_mem_s) begin
         exc_s = EXC_NONE;
      end else if (!funct3_legal(ex_funct3_i, ex_store_i)) begin
         exc_s = EXC_ILL;
      end else if (misaligned(ex_funct3_i, ex_alu_p_i[1:0])) begin
         exc_s = EXC_MISAL;
      end else begin
         exc_s = EXC_NONE;
      end
   end

   // Next-state logic; acceptance from IDLE and RESP behaves identically.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) next_state_s = go_req_s ? ST_REQ : ST_RESP;
            else          next_state_s = ST_IDLE;
         end
         ST_REQ: begin
            if (mem.mem_ack_i || timeout_s) next_state_s = ST_RESP;
            else                            next_state_s = ST_REQ;
         end
         ST_RESP: begin
            if (accept_s)        next_state_s = go_req_s ? ST_REQ : ST_RESP;
            else if (wb_ready_i) next_state_s = ST_IDLE;
            else                 next_state_s = ST_RESP;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= next_state_s;
   end

   // Registered memory-port and write-back outputs plus in-flight op context.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
         mem_wmask_r <= 4'b0000;
         cnt_r       <= '0;
         op_f3_r     <= 3'b000;
         op_addr_r   <= 32'h0000_0000;
         op_rd_r     <= 5'd0;
         op_rd_we_r  <= 1'b0;
         op_st_r     <= 1'b0;
         wb_valid_r  <= 1'b0;
         wb_result_r <= 32'h0000_0000;
         wb_rd_r     <= 5'd0;
         wb_rd_we_r  <= 1'b0;
         wb_exc_r    <= EXC_NONE;
      end else if (accept_s) begin
         if (go_req_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= ex_store_i;
            mem_addr_r  <= {ex_alu_p_i[31:2], 2'b00};
            mem_wdata_r <= ex_store_i ? store_data(ex_funct3_i, ex_wdata_i) : 32'h0000_0000;
            mem_wmask_r <= ex_store_i ? store_mask(ex_funct3_i, ex_alu_p_i[1:0]) : 4'b0000;
            cnt_r       <= '0;
            op_f3_r     <= ex_funct3_i;
            op_addr_r   <= ex_alu_p_i;
            op_rd_r     <= ex_rd_i;
            op_rd_we_r  <= ex_rd_we_i;
            op_st_r     <= ex_store_i;
            wb_valid_r  <= 1'b0;
         end else begin
            // Pass-through result and faulting address are both the ALU value.
            wb_valid_r  <= 1'b1;
            wb_result_r <= ex_alu_p_i;
            wb_rd_r     <= ex_rd_i;
            wb_rd_we_r  <= is_mem_s ? 1'b0 : ex_rd_we_i;
            wb_exc_r    <= exc_s;
         end
      end else if (state_r == ST_REQ) begin
         if (mem.mem_ack_i) begin
            mem_req_r   <= 1'b0;
            wb_valid_r  <= 1'b1;
            wb_result_r <= op_st_r ? op_addr_r
                                   : load_extract(op_f3_r, op_addr_r[1:0], mem.mem_rdata_i);
            wb_rd_r     <= op_rd_r;
            wb_rd_we_r  <= op_st_r ? 1'b0 : op_rd_we_r;
            wb_exc_r    <= EXC_NONE;
         end else if (timeout_s) begin
            mem_req_r   <= 1'b0;
            wb_valid_r  <= 1'b1;
            wb_result_r <= op_addr_r;
            wb_rd_r     <= op_rd_r;
            wb_rd_we_r  <= 1'b0;
            wb_exc_r    <= EXC_TOUT;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end else if ((state_r == ST_RESP) && wb_ready_i) begin
         wb_valid_r <= 1'b0;
      end
   end

   assign mem.mem_req_o   = mem_req_r;
   assign mem.mem_we_o    = mem_we_r;
   assign mem.mem_addr_o  = mem_addr_r;
   assign mem.mem_wdata_o = mem_wdata_r;
   assign mem.mem_wmask_o = mem_wmask_r;
   assign wb_valid_o      = wb_valid_r;
   assign wb_result_o     = wb_result_r;
   assign wb_rd_o         = wb_rd_r;
   assign wb_rd_we_o      = wb_rd_we_r;
   assign wb_exc_code_o   = wb_exc_r;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (TIMEOUT=4): loads, stores, exceptions,
// bus timeout, back-to-back pass-through under WB back-pressure, reset in REQ.
module tb_riscv_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready, ex_load, ex_store, ex_rd_we;
   logic [31:0] ex_alu_p, ex_wdata;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd;
   logic        wb_valid, wb_ready, wb_rd_we;
   logic [31:0] wb_result;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_exc;
   int          n_vec = 0;
   int          n_err = 0;

   riscv_lsu_if mem_bus ();

   riscv_lsu #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_alu_p_i(ex_alu_p),
      .ex_wdata_i(ex_wdata), .ex_funct3_i(ex_funct3), .ex_load_i(ex_load),
      .ex_store_i(ex_store), .ex_rd_i(ex_rd), .ex_rd_we_i(ex_rd_we),
      .mem(mem_bus.master),
      .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_result_o(wb_result),
      .wb_rd_o(wb_rd), .wb_rd_we_o(wb_rd_we), .wb_exc_code_o(wb_exc)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present one instruction and hold it across exactly one accepting edge.
   task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic rd_we);
      ex_load = ld; ex_store = st; ex_funct3 = f3; ex_alu_p = addr;
      ex_wdata = wdata; ex_rd = rd; ex_rd_we = rd_we; ex_valid = 1'b1;
      @(negedge clk);
      check("ex_ready", 32'(ex_ready), 32'd1);
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
   endtask

   // Wait n cycles, pulse ack with rdata, end on the negedge of the result cycle.
   task automatic ack_after(input int n, input logic [31:0] rdata);
      repeat (n) begin @(posedge clk); #1; end
      mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = rdata;
      @(posedge clk); #1;
      mem_bus.mem_ack_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
      send(1'b1, 1'b0, f3, addr, 32'h0, 5'd4, 1'b1);
      ack_after(0, rdata);
      check(tag, wb_result, exp);
      step();
   endtask

   initial begin
      logic [15:0] rdy_pat;
      int hi, sent, recv;
      bit done;
      rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_rd_we = 1'b0;
      ex_alu_p = 32'h0; ex_wdata = 32'h0; ex_funct3 = 3'b000; ex_rd = 5'd0; wb_ready = 1'b1;
      mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = 32'h0;
      @(negedge clk);
      check("rst_req", 32'(mem_bus.mem_req_o), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_addr", mem_bus.mem_addr_o, 32'h0);
      check("rst_result", wb_result, 32'h0);
      check("rst_ready", 32'(ex_ready), 32'd1);
      step(); rst = 1'b0;

      // Pass-through ALU op: valid the cycle after acceptance, funct3 ignored.
      send(1'b0, 1'b0, 3'b111, 32'h1234_5678, 32'h0, 5'd3, 1'b1);
      @(negedge clk);
      check("alu_valid", 32'(wb_valid), 32'd1);
      check("alu_result", wb_result, 32'h1234_5678);
      check("alu_rd", 32'(wb_rd), 32'd3);
      check("alu_rd_we", 32'(wb_rd_we), 32'd1);
      check("alu_req", 32'(mem_bus.mem_req_o), 32'd0);
      step();

      // LW 0x1000.
      send(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 5'd5, 1'b1);
      @(negedge clk);
      check("lw_req", 32'(mem_bus.mem_req_o), 32'd1);
      check("lw_addr", mem_bus.mem_addr_o, 32'h1000);
      check("lw_we", 32'(mem_bus.mem_we_o), 32'd0);
      check("lw_wmask", 32'(mem_bus.mem_wmask_o), 32'd0);
      check("lw_ready_in_req", 32'(ex_ready), 32'd0);
      ack_after(1, 32'hDEAD_BEEF);
      check("lw_valid", 32'(wb_valid), 32'd1);
      check("lw_result", wb_result, 32'hDEAD_BEEF);
      check("lw_rd_we", 32'(wb_rd_we), 32'd1);
      check("lw_rd", 32'(wb_rd), 32'd5);
      check("lw_req_drop", 32'(mem_bus.mem_req_o), 32'd0);
      step();

      load_case("lb_sext", 3'b000, 32'h1003, 32'h8012_3456, 32'hFFFF_FF80);
      load_case("lbu_zext", 3'b100, 32'h1003, 32'h8012_3456, 32'h0000_0080);
      load_case("lhu_hi", 3'b101, 32'h1002, 32'h8012_3456, 32'h0000_8012);
      load_case("lh_hi", 3'b001, 32'h1002, 32'h8012_3456, 32'hFFFF_8012);
      load_case("lb_lane1", 3'b000, 32'h1001, 32'h8012_3456, 32'h0000_0034);

      // SH 0x1002.
      send(1'b0, 1'b1, 3'b001, 32'h1002, 32'h1234_ABCD, 5'd9, 1'b1);
      @(negedge clk);
      check("sh_we", 32'(mem_bus.mem_we_o), 32'd1);
      check("sh_wmask", 32'(mem_bus.mem_wmask_o), 32'hC);
      check("sh_wdata", mem_bus.mem_wdata_o, 32'hABCD_ABCD);
      check("sh_addr", mem_bus.mem_addr_o, 32'h1000);
      ack_after(0, 32'h0);
      check("sh_valid", 32'(wb_valid), 32'd1);
      check("sh_rd_we", 32'(wb_rd_we), 32'd0);
      step();

      // SB 0x1001.
      send(1'b0, 1'b1, 3'b000, 32'h1001, 32'h0000_00A5, 5'd9, 1'b1);
      @(negedge clk);
      check("sb_wmask", 32'(mem_bus.mem_wmask_o), 32'h2);
      check("sb_wdata", mem_bus.mem_wdata_o, 32'hA5A5_A5A5);
      ack_after(0, 32'h0);
      step();

      // Load and store both set: store.
      send(1'b1, 1'b1, 3'b010, 32'h5000, 32'h1122_3344, 5'd2, 1'b1);
      @(negedge clk);
      check("both_we", 32'(mem_bus.mem_we_o), 32'd1);
      check("both_wmask", 32'(mem_bus.mem_wmask_o), 32'hF);
      check("both_wdata", mem_bus.mem_wdata_o, 32'h1122_3344);
      ack_after(1, 32'h0);
      check("both_rd_we", 32'(wb_rd_we), 32'd0);
      step();

      // Misaligned LW: no request.
      send(1'b1, 1'b0, 3'b010, 32'h1001, 32'h0, 5'd6, 1'b1);
      @(negedge clk);
      check("mis_req", 32'(mem_bus.mem_req_o), 32'd0);
      check("mis_valid", 32'(wb_valid), 32'd1);
      check("mis_exc", 32'(wb_exc), 32'd1);
      check("mis_result", wb_result, 32'h1001);
      check("mis_rd_we", 32'(wb_rd_we), 32'd0);
      step();

      send(1'b1, 1'b0, 3'b001, 32'h1003, 32'h0, 5'd6, 1'b1);
      @(negedge clk);
      check("mis_lh_exc", 32'(wb_exc), 32'd1);
      step();

      // Illegal widths.
      send(1'b0, 1'b1, 3'b011, 32'h2000, 32'h0, 5'd6, 1'b1);
      @(negedge clk);
      check("ill_sw_exc", 32'(wb_exc), 32'd3);
      check("ill_sw_req", 32'(mem_bus.mem_req_o), 32'd0);
      step();
      send(1'b1, 1'b0, 3'b110, 32'h2000, 32'h0, 5'd6, 1'b1);
      @(negedge clk);
      check("ill_ld_exc", 32'(wb_exc), 32'd3);
      step();

      // Timeout: req high 5 cycles then exc 10.
      send(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 5'd7, 1'b1);
      hi = 0; done = 1'b0;
      for (int i = 0; i < 12 && !done; i++) begin
         @(negedge clk);
         if (mem_bus.mem_req_o) hi++;
         if (wb_valid) done = 1'b1;
         else step();
      end
      check("tout_done", 32'(done), 32'd1);
      check("tout_req_cycles", 32'(hi), 32'd5);
      check("tout_exc", 32'(wb_exc), 32'd2);
      check("tout_result", wb_result, 32'h3000);
      check("tout_rd_we", 32'(wb_rd_we), 32'd0);
      step();

      // Ack on the final allowed cycle wins over timeout.
      send(1'b1, 1'b0, 3'b010, 32'h3004, 32'h0, 5'd7, 1'b1);
      ack_after(4, 32'hCAFE_F00D);
      check("late_ack_exc", 32'(wb_exc), 32'd0);
      check("late_ack_result", wb_result, 32'hCAFE_F00D);
      check("late_ack_rd_we", 32'(wb_rd_we), 32'd1);
      step();

      // Back-to-back ALU ops under WB back-pressure.
      rdy_pat = 16'b1011_0010_1101_0110;
      sent = 0; recv = 0;
      for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
         ex_valid = (sent < 8); ex_load = 1'b0; ex_store = 1'b0; ex_rd_we = 1'b1;
         ex_alu_p = 32'h100 + 32'(sent) * 32'h11; ex_rd = 5'(sent + 1);
         wb_ready = rdy_pat[cyc % 16];
         @(negedge clk);
         if (wb_valid && wb_ready) begin
            check("b2b_result", wb_result, 32'h100 + 32'(recv) * 32'h11);
            check("b2b_rd", 32'(wb_rd), 32'(recv + 1));
            recv++;
         end
         if (ex_valid && ex_ready) sent++;
         step();
      end
      ex_valid = 1'b0; wb_ready = 1'b1;
      check("b2b_count", 32'(recv), 32'd8);
      step();

      // Reset during REQ drops req immediately; a later ack is ignored.
      send(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd8, 1'b1);
      @(negedge clk);
      check("rreq_req", 32'(mem_bus.mem_req_o), 32'd1);
      #1 rst = 1'b1;
      #1 check("rreq_async_drop", 32'(mem_bus.mem_req_o), 32'd0);
      step(); rst = 1'b0;
      mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h5555_AAAA;
      step(); mem_bus.mem_ack_i = 1'b0;
      @(negedge clk);
      check("rreq_ack_ignored", 32'(wb_valid), 32'd0);
      check("rreq_req_after", 32'(mem_bus.mem_req_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
